alu_issue_queue: RTL and testbench

In-order-age issue queue that sits directly upstream of the integer ALU stage. It buffers decoded ALU and branch micro-ops until both source operands are available, capturing late operands from two writeback/wakeup buses, and issues at most one ready micro-op per cycle, oldest first, into the ALU's registered inputs. A branch redirect from the ALU flushes every entry.

---
 rtl/alu_issue_queue_pkg.sv | 30 +++
 rtl/alu_issue_select.sv | 22 ++
 rtl/alu_issue_queue.sv | 237 +++++++++++++++++++++++
 tb/tb_alu_issue_queue.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_queue_pkg.sv
// Shared types and constants for the ALU issue queue: opcode/tag widths, the ALU_NOP
// encoding, the queue entry record and the legal DEPTH range.
package alu_issue_queue_pkg;

    localparam int unsigned ALU_XLEN   = 32;
    localparam int unsigned MIC_OP_W   = 5;
    localparam int unsigned ARCH_REG_W = 5;

    // Zero opcode sends the ALU down its default path: no writeback, no jump.
    localparam logic [MIC_OP_W-1:0] ALU_NOP = '0;

    typedef struct packed {
        logic [MIC_OP_W-1:0]   op;
        logic                  src1_rdy;
        logic                  src2_rdy;
        logic [ARCH_REG_W-1:0] src1_tag;
        logic [ARCH_REG_W-1:0] src2_tag;
        logic [ALU_XLEN-1:0]   src1_data;
        logic [ALU_XLEN-1:0]   src2_data;
        logic [ALU_XLEN-1:0]   offset;
        logic [ALU_XLEN-1:0]   inst_addr;
        logic [ARCH_REG_W-1:0] dest;
        logic                  predict;
    } iq_entry_t;

    function automatic bit depth_ok(input int d);
        return (d >= 2) && (d <= 8);
    endfunction

endpackage

// File: rtl/alu_issue_select.sv
// Find-first-ready priority picker: returns the lowest index whose ready bit is set.
module alu_issue_select #(
    parameter int unsigned Depth = 4,
    parameter int unsigned IdxW  = 2
) (
    input  logic [Depth-1:0] ready_i,
    output logic [IdxW-1:0]  idx_o,
    output logic             found_o
);

    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        for (int i = Depth - 1; i >= 0; i--) begin
            if (ready_i[i]) begin
                found_o = 1'b1;
                idx_o   = IdxW'(i);
            end
        end
    end

endmodule

// File: rtl/alu_issue_queue.sv
// Collapsing, oldest-first issue queue in front of the integer ALU with two wakeup buses.
// Optional performance counters are built when ALU_ISSUEQ_PERF_EN is defined.
module alu_issue_queue
    import alu_issue_queue_pkg::*;
#(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned WIDTH_ALU = ALU_XLEN
) (
    input  logic                  Clk,
    input  logic                  Rest,
    input  logic                  DispValid,
    output logic                  DispReady,
    input  logic [MIC_OP_W-1:0]   DispMicOperate,
    input  logic                  DispSrc1Ready,
    input  logic                  DispSrc2Ready,
    input  logic [ARCH_REG_W-1:0] DispSrc1Tag,
    input  logic [ARCH_REG_W-1:0] DispSrc2Tag,
    input  logic [WIDTH_ALU-1:0]  DispSrc1Data,
    input  logic [WIDTH_ALU-1:0]  DispSrc2Data,
    input  logic [WIDTH_ALU-1:0]  DispOffset,
    input  logic [WIDTH_ALU-1:0]  DispInstAddr,
    input  logic [ARCH_REG_W-1:0] DispReDataAddr,
    input  logic                  DispPredict,
    input  logic                  WakeValid0,
    input  logic [ARCH_REG_W-1:0] WakeTag0,
    input  logic [WIDTH_ALU-1:0]  WakeData0,
    input  logic                  WakeValid1,
    input  logic [ARCH_REG_W-1:0] WakeTag1,
    input  logic [WIDTH_ALU-1:0]  WakeData1,
    input  logic                  FlushValid,
    output logic                  IssueValid,
    output logic [MIC_OP_W-1:0]   IssueMicOperate,
    output logic [WIDTH_ALU-1:0]  IssueSrc1,
    output logic [WIDTH_ALU-1:0]  IssueSrc2,
    output logic [WIDTH_ALU-1:0]  IssueOffset,
    output logic [WIDTH_ALU-1:0]  IssueInstAddr,
    output logic [ARCH_REG_W-1:0] IssueReDataAddr,
    output logic                  IssuePredict
`ifdef ALU_ISSUEQ_PERF_EN
    ,
    output logic [31:0]           PerfIssueCnt,
    output logic [31:0]           PerfStallCnt
`endif
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned IDX_W = $clog2(DEPTH);

    if (!depth_ok(int'(DEPTH)) || (WIDTH_ALU != ALU_XLEN)) begin : g_param_check
        $error("alu_issue_queue: DEPTH must be 2..8 and WIDTH_ALU must equal ALU_XLEN");
    end

    // Tag 0 is r0 and never matches; bus 0 wins when both buses carry the same tag.
    function automatic iq_entry_t apply_wake(
        input iq_entry_t             e,
        input logic                  v0,
        input logic [ARCH_REG_W-1:0] t0,
        input logic [WIDTH_ALU-1:0]  d0,
        input logic                  v1,
        input logic [ARCH_REG_W-1:0] t1,
        input logic [WIDTH_ALU-1:0]  d1
    );
        iq_entry_t r = e;
        if (!r.src1_rdy && (r.src1_tag != '0)) begin
            if (v0 && (t0 == r.src1_tag)) begin
                r.src1_rdy  = 1'b1;
                r.src1_data = d0;
            end else if (v1 && (t1 == r.src1_tag)) begin
                r.src1_rdy  = 1'b1;
                r.src1_data = d1;
            end
        end
        if (!r.src2_rdy && (r.src2_tag != '0)) begin
            if (v0 && (t0 == r.src2_tag)) begin
                r.src2_rdy  = 1'b1;
                r.src2_data = d0;
            end else if (v1 && (t1 == r.src2_tag)) begin
                r.src2_rdy  = 1'b1;
                r.src2_data = d1;
            end
        end
        return r;
    endfunction

    iq_entry_t             entries_q [DEPTH];
    iq_entry_t             entries_d [DEPTH];
    iq_entry_t             woken     [DEPTH];
    iq_entry_t             incoming;
    iq_entry_t             sel_entry;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [CNT_W-1:0]      wr_ptr;
    logic [DEPTH-1:0]      ready_vec;
    logic [IDX_W-1:0]      sel_idx;
    logic                  sel_found;
    logic                  disp_fire;

    logic                  issue_valid_q;
    logic [MIC_OP_W-1:0]   issue_op_q;
    logic [WIDTH_ALU-1:0]  issue_src1_q, issue_src2_q, issue_offset_q, issue_addr_q;
    logic [ARCH_REG_W-1:0] issue_dest_q;
    logic                  issue_predict_q;

    assign DispReady = (count_q != CNT_W'(DEPTH));
    assign disp_fire = DispValid && DispReady;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ready_vec[i] = (CNT_W'(i) < count_q) && entries_q[i].src1_rdy
                           && entries_q[i].src2_rdy;
        end
    end

    alu_issue_select #(
        .Depth (DEPTH),
        .IdxW  (IDX_W)
    ) u_select (
        .ready_i (ready_vec),
        .idx_o   (sel_idx),
        .found_o (sel_found)
    );

    assign sel_entry = entries_q[sel_idx];

    always_comb begin
        incoming = '{
            op:        DispMicOperate,
            src1_rdy:  DispSrc1Ready,
            src2_rdy:  DispSrc2Ready,
            src1_tag:  DispSrc1Tag,
            src2_tag:  DispSrc2Tag,
            src1_data: DispSrc1Data,
            src2_data: DispSrc2Data,
            offset:    DispOffset,
            inst_addr: DispInstAddr,
            dest:      DispReDataAddr,
            predict:   DispPredict
        };
        // Same-cycle wakeup is forwarded into the dispatching micro-op.
        incoming = apply_wake(incoming, WakeValid0, WakeTag0, WakeData0,
                              WakeValid1, WakeTag1, WakeData1);
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            woken[i] = apply_wake(entries_q[i], WakeValid0, WakeTag0, WakeData0,
                                  WakeValid1, WakeTag1, WakeData1);
        end
        entries_d = woken;
        count_d   = count_q;
        wr_ptr    = count_q;
        if (sel_found) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                if (IDX_W'(i) >= sel_idx) begin
                    entries_d[i] = woken[i + 1];
                end
            end
            count_d = count_q - 1'b1;
            wr_ptr  = count_q - 1'b1;
        end
        if (disp_fire) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (CNT_W'(i) == wr_ptr) begin
                    entries_d[i] = incoming;
                end
            end
            count_d = count_d + 1'b1;
        end
        if (FlushValid) begin
            count_d = '0;
        end
    end

    always_ff @(posedge Clk or negedge Rest) begin
        if (!Rest) begin
            count_q         <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            issue_valid_q   <= 1'b0;
            issue_op_q      <= ALU_NOP;
            issue_src1_q    <= '0;
            issue_src2_q    <= '0;
            issue_offset_q  <= '0;
            issue_addr_q    <= '0;
            issue_dest_q    <= '0;
            issue_predict_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            entries_q <= entries_d;
            if (!FlushValid && sel_found) begin
                issue_valid_q   <= 1'b1;
                issue_op_q      <= sel_entry.op;
                issue_src1_q    <= sel_entry.src1_data;
                issue_src2_q    <= sel_entry.src2_data;
                issue_offset_q  <= sel_entry.offset;
                issue_addr_q    <= sel_entry.inst_addr;
                issue_dest_q    <= sel_entry.dest;
                issue_predict_q <= sel_entry.predict;
            end else begin
                issue_valid_q <= 1'b0;
                issue_op_q    <= ALU_NOP;
            end
        end
    end

    assign IssueValid      = issue_valid_q;
    assign IssueMicOperate = issue_op_q;
    assign IssueSrc1       = issue_src1_q;
    assign IssueSrc2       = issue_src2_q;
    assign IssueOffset     = issue_offset_q;
    assign IssueInstAddr   = issue_addr_q;
    assign IssueReDataAddr = issue_dest_q;
    assign IssuePredict    = issue_predict_q;

`ifdef ALU_ISSUEQ_PERF_EN
    logic [31:0] perf_issue_q, perf_stall_q;

    // Cleared by reset only; a flush leaves the counts intact.
    always_ff @(posedge Clk or negedge Rest) begin
        if (!Rest) begin
            perf_issue_q <= '0;
            perf_stall_q <= '0;
        end else begin
            if (!FlushValid && sel_found) begin
                perf_issue_q <= perf_issue_q + 32'd1;
            end
            if (DispValid && !DispReady) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign PerfIssueCnt = perf_issue_q;
    assign PerfStallCnt = perf_stall_q;
`endif

endmodule

// File: tb/tb_alu_issue_queue.sv
// Self-checking bench for alu_issue_queue: table-driven back-to-back dispatch/issue plus
// directed wakeup, full-queue, ordering, flush and asynchronous-reset sequences.
module tb_alu_issue_queue;
    import alu_issue_queue_pkg::*;

    logic                  Clk;
    logic                  Rest;
    logic                  DispValid;
    logic                  DispReady;
    logic [MIC_OP_W-1:0]   DispMicOperate;
    logic                  DispSrc1Ready, DispSrc2Ready;
    logic [ARCH_REG_W-1:0] DispSrc1Tag, DispSrc2Tag;
    logic [31:0]           DispSrc1Data, DispSrc2Data, DispOffset, DispInstAddr;
    logic [ARCH_REG_W-1:0] DispReDataAddr;
    logic                  DispPredict;
    logic                  WakeValid0, WakeValid1;
    logic [ARCH_REG_W-1:0] WakeTag0, WakeTag1;
    logic [31:0]           WakeData0, WakeData1;
    logic                  FlushValid;
    logic                  IssueValid;
    logic [MIC_OP_W-1:0]   IssueMicOperate;
    logic [31:0]           IssueSrc1, IssueSrc2, IssueOffset, IssueInstAddr;
    logic [ARCH_REG_W-1:0] IssueReDataAddr;
    logic                  IssuePredict;

    int unsigned n_total  = 0;
    int unsigned n_passed = 0;

    alu_issue_queue #(
        .DEPTH     (4),
        .WIDTH_ALU (32)
    ) dut (
        .Clk             (Clk),
        .Rest            (Rest),
        .DispValid       (DispValid),
        .DispReady       (DispReady),
        .DispMicOperate  (DispMicOperate),
        .DispSrc1Ready   (DispSrc1Ready),
        .DispSrc2Ready   (DispSrc2Ready),
        .DispSrc1Tag     (DispSrc1Tag),
        .DispSrc2Tag     (DispSrc2Tag),
        .DispSrc1Data    (DispSrc1Data),
        .DispSrc2Data    (DispSrc2Data),
        .DispOffset      (DispOffset),
        .DispInstAddr    (DispInstAddr),
        .DispReDataAddr  (DispReDataAddr),
        .DispPredict     (DispPredict),
        .WakeValid0      (WakeValid0),
        .WakeTag0        (WakeTag0),
        .WakeData0       (WakeData0),
        .WakeValid1      (WakeValid1),
        .WakeTag1        (WakeTag1),
        .WakeData1       (WakeData1),
        .FlushValid      (FlushValid),
        .IssueValid      (IssueValid),
        .IssueMicOperate (IssueMicOperate),
        .IssueSrc1       (IssueSrc1),
        .IssueSrc2       (IssueSrc2),
        .IssueOffset     (IssueOffset),
        .IssueInstAddr   (IssueInstAddr),
        .IssueReDataAddr (IssueReDataAddr),
        .IssuePredict    (IssuePredict)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [MIC_OP_W-1:0]   op;
        logic [31:0]           s1;
        logic [31:0]           s2;
        logic [31:0]           off;
        logic [31:0]           addr;
        logic [ARCH_REG_W-1:0] dest;
        logic                  pred;
    } vec_t;

    localparam int NV = 6;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_passed++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        DispValid      = 1'b0;
        DispMicOperate = '0;
        DispSrc1Ready  = 1'b0;
        DispSrc2Ready  = 1'b0;
        DispSrc1Tag    = '0;
        DispSrc2Tag    = '0;
        DispSrc1Data   = '0;
        DispSrc2Data   = '0;
        DispOffset     = '0;
        DispInstAddr   = '0;
        DispReDataAddr = '0;
        DispPredict    = 1'b0;
        WakeValid0     = 1'b0;
        WakeTag0       = '0;
        WakeData0      = '0;
        WakeValid1     = 1'b0;
        WakeTag1       = '0;
        WakeData1      = '0;
        FlushValid     = 1'b0;
    endtask

    task automatic disp(input logic [4:0] op, input logic r1, input logic [4:0] t1,
                        input logic [31:0] d1, input logic r2, input logic [4:0] t2,
                        input logic [31:0] d2);
        DispValid      = 1'b1;
        DispMicOperate = op;
        DispSrc1Ready  = r1;
        DispSrc1Tag    = t1;
        DispSrc1Data   = d1;
        DispSrc2Ready  = r2;
        DispSrc2Tag    = t2;
        DispSrc2Data   = d2;
        DispOffset     = 32'h0;
        DispInstAddr   = 32'h0;
        DispReDataAddr = 5'd1;
        DispPredict    = 1'b0;
    endtask

    task automatic wake0(input logic [4:0] t, input logic [31:0] d);
        WakeValid0 = 1'b1;
        WakeTag0   = t;
        WakeData0  = d;
    endtask

    task automatic wake1(input logic [4:0] t, input logic [31:0] d);
        WakeValid1 = 1'b1;
        WakeTag1   = t;
        WakeData1  = d;
    endtask

    initial begin
        vecs[0] = '{5'd1,  32'd5,        32'd7,        32'h10,       32'h1000, 5'd3,  1'b0};
        vecs[1] = '{5'd2,  32'hFFFFFFFF, 32'd1,        32'hFFFFFFF0, 32'h1004, 5'd31, 1'b1};
        vecs[2] = '{5'h1F, 32'd0,        32'd0,        32'd0,        32'h1008, 5'd0,  1'b0};
        vecs[3] = '{5'd7,  32'hDEADBEEF, 32'h12345678, 32'h4,        32'h100C, 5'd7,  1'b1};
        vecs[4] = '{5'h10, 32'h80000000, 32'h7FFFFFFF, 32'h8,        32'h1010, 5'd16, 1'b0};
        vecs[5] = '{5'd3,  32'hA5A5A5A5, 32'h5A5A5A5A, 32'h20,       32'h1014, 5'd1,  1'b1};

        // Reset state, before any clock edge
        Rest = 1'b0;
        idle();
        #12;
        check("rst_valid", 64'(IssueValid), 64'd0);
        check("rst_op", 64'(IssueMicOperate), 64'(ALU_NOP));
        check("rst_src1", 64'(IssueSrc1), 64'd0);
        check("rst_ready", 64'(DispReady), 64'd1);
        @(negedge Clk);
        Rest = 1'b1;
        tick();

        // Back-to-back dispatch, each issues on the following edge
        for (int i = 0; i <= NV; i++) begin
            if (i < NV) begin
                DispValid      = 1'b1;
                DispMicOperate = vecs[i].op;
                DispSrc1Ready  = 1'b1;
                DispSrc2Ready  = 1'b1;
                DispSrc1Tag    = '0;
                DispSrc2Tag    = '0;
                DispSrc1Data   = vecs[i].s1;
                DispSrc2Data   = vecs[i].s2;
                DispOffset     = vecs[i].off;
                DispInstAddr   = vecs[i].addr;
                DispReDataAddr = vecs[i].dest;
                DispPredict    = vecs[i].pred;
            end else begin
                idle();
            end
            tick();
            if (i > 0) begin
                check("tbl_valid", 64'(IssueValid), 64'd1);
                check("tbl_op", 64'(IssueMicOperate), 64'(vecs[i-1].op));
                check("tbl_src1", 64'(IssueSrc1), 64'(vecs[i-1].s1));
                check("tbl_src2", 64'(IssueSrc2), 64'(vecs[i-1].s2));
                check("tbl_off", 64'(IssueOffset), 64'(vecs[i-1].off));
                check("tbl_addr", 64'(IssueInstAddr), 64'(vecs[i-1].addr));
                check("tbl_dest", 64'(IssueReDataAddr), 64'(vecs[i-1].dest));
                check("tbl_pred", 64'(IssuePredict), 64'(vecs[i-1].pred));
            end
        end
        tick();
        check("empty_valid", 64'(IssueValid), 64'd0);
        check("empty_nop", 64'(IssueMicOperate), 64'(ALU_NOP));
        check("empty_hold_src1", 64'(IssueSrc1), 64'(vecs[NV-1].s1));

        // Late wakeup on bus 1, two cycles after dispatch
        disp(5'd2, 1'b1, 5'd0, 32'd9, 1'b0, 5'd3, 32'd0);
        tick();
        idle();
        tick();
        check("wk_wait0", 64'(IssueValid), 64'd0);
        wake1(5'd3, 32'h1234);
        tick();
        idle();
        check("wk_wait1", 64'(IssueValid), 64'd0);
        tick();
        check("wk_valid", 64'(IssueValid), 64'd1);
        check("wk_src2", 64'(IssueSrc2), 64'h1234);
        check("wk_src1", 64'(IssueSrc1), 64'd9);
        tick();
        check("wk_drained", 64'(IssueValid), 64'd0);

        // Dispatch-cycle forwarding from bus 0
        disp(5'd4, 1'b0, 5'd8, 32'd0, 1'b1, 5'd0, 32'd2);
        wake0(5'd8, 32'h88);
        tick();
        idle();
        tick();
        check("fwd_valid", 64'(IssueValid), 64'd1);
        check("fwd_src1", 64'(IssueSrc1), 64'h88);

        // Both buses carry the same tag: bus 0 data wins
        disp(5'd5, 1'b0, 5'd9, 32'd0, 1'b1, 5'd0, 32'd1);
        tick();
        idle();
        wake0(5'd9, 32'hB0);
        wake1(5'd9, 32'hB1);
        tick();
        idle();
        tick();
        check("prio_op", 64'(IssueMicOperate), 64'd5);
        check("prio_src1", 64'(IssueSrc1), 64'hB0);
        tick();

        // Fill the queue with waiting micro-ops
        for (int k = 1; k <= 4; k++) begin
            disp(5'(k + 8), 1'b0, 5'(k), 32'd0, 1'b1, 5'd0, 32'd0);
            tick();
        end
        check("full_ready", 64'(DispReady), 64'd0);
        disp(5'h1F, 1'b0, 5'd5, 32'd0, 1'b1, 5'd0, 32'd0);
        tick();
        check("full_hold_ready", 64'(DispReady), 64'd0);
        check("full_no_issue", 64'(IssueValid), 64'd0);
        wake0(5'd2, 32'hAA);
        tick();
        WakeValid0 = 1'b0;
        check("full_wake_ready", 64'(DispReady), 64'd0);
        tick();
        check("full_iss_valid", 64'(IssueValid), 64'd1);
        check("full_iss_op", 64'(IssueMicOperate), 64'd10);
        check("full_iss_src1", 64'(IssueSrc1), 64'hAA);
        check("full_freed", 64'(DispReady), 64'd1);
        tick();
        check("full_refill_ready", 64'(DispReady), 64'd0);
        check("full_refill_valid", 64'(IssueValid), 64'd0);
        idle();
        tick();
        check("full_still", 64'(DispReady), 64'd0);

        // Flush with a concurrent dispatch
        disp(5'h1E, 1'b1, 5'd0, 32'd1, 1'b1, 5'd0, 32'd1);
        FlushValid = 1'b1;
        tick();
        idle();
        check("fl_ready", 64'(DispReady), 64'd1);
        check("fl_valid", 64'(IssueValid), 64'd0);
        check("fl_op", 64'(IssueMicOperate), 64'(ALU_NOP));
        tick();
        check("fl_discard", 64'(IssueValid), 64'd0);
        wake0(5'd1, 32'h1);
        wake1(5'd3, 32'h3);
        tick();
        idle();
        tick();
        check("fl_gone", 64'(IssueValid), 64'd0);

        // Entries 0 and 2 ready, 1 waiting: oldest first, order kept after collapse
        disp(5'd1, 1'b0, 5'd6, 32'd0, 1'b1, 5'd0, 32'd0);
        tick();
        disp(5'd2, 1'b0, 5'd7, 32'd0, 1'b1, 5'd0, 32'd0);
        tick();
        disp(5'd3, 1'b1, 5'd0, 32'h33, 1'b1, 5'd0, 32'd0);
        wake0(5'd6, 32'h66);
        tick();
        idle();
        check("ord_none", 64'(IssueValid), 64'd0);
        tick();
        check("ord_a_op", 64'(IssueMicOperate), 64'd1);
        check("ord_a_src1", 64'(IssueSrc1), 64'h66);
        tick();
        check("ord_c_op", 64'(IssueMicOperate), 64'd3);
        check("ord_c_src1", 64'(IssueSrc1), 64'h33);
        tick();
        check("ord_b_wait", 64'(IssueValid), 64'd0);
        wake1(5'd7, 32'h77);
        tick();
        idle();
        tick();
        check("ord_b_op", 64'(IssueMicOperate), 64'd2);
        check("ord_b_src1", 64'(IssueSrc1), 64'h77);

        // Asynchronous reset while IssueValid is high
        disp(5'd6, 1'b1, 5'd0, 32'd5, 1'b1, 5'd0, 32'd7);
        tick();
        idle();
        tick();
        check("ar_pre_valid", 64'(IssueValid), 64'd1);
        #2;
        Rest = 1'b0;
        #1;
        check("ar_valid", 64'(IssueValid), 64'd0);
        check("ar_op", 64'(IssueMicOperate), 64'd0);
        check("ar_src1", 64'(IssueSrc1), 64'd0);
        check("ar_src2", 64'(IssueSrc2), 64'd0);
        check("ar_ready", 64'(DispReady), 64'd1);
        @(negedge Clk);
        Rest = 1'b1;
        tick();
        check("ar_post_valid", 64'(IssueValid), 64'd0);

        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end

endmodule
